// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-lane data memory with sized, extended loads and a handshaked debug dump.
// Pipeline accesses use an asynchronous read (read-first on same-cycle store); the dump streams words in index order.
module data_memory_responder #(
   parameter int NB_DATA           = 32,
   parameter int NB_MEM_DATA_ADDR  = 32,
   parameter int N_WORDS           = 256,
   parameter int NB_LOAD_STORE_SEL = 2
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic                         i_enable,
   input  logic [NB_MEM_DATA_ADDR-1:0]  i_addr,
   input  logic [NB_DATA-1:0]           i_wr_data,
   input  logic                         i_wr_enable,
   input  logic                         i_rd_enable,
   input  logic [NB_LOAD_STORE_SEL-1:0] i_load_store_selector,
   input  logic                         i_load_unsigned,
   output logic [NB_DATA-1:0]           o_data,
   output logic                         o_misaligned,
   input  logic                         i_dump_start,
   output logic [NB_DATA-1:0]           o_dump_data,
   output logic                         o_dump_valid,
   input  logic                         i_dump_ready,
   output logic                         o_dump_busy,
   output logic                         o_dump_done
);
   localparam int NB_IDX = $clog2(N_WORDS);
   typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} dump_state_t;
   dump_state_t state, next_state;
   logic [NB_DATA-1:0] mem [N_WORDS];
   logic [NB_IDX-1:0]  idx, ptr;
   logic [1:0]         lane;
   logic [4:0]         shamt;
   logic               is_byte, is_half, misaligned, accept, unused_addr;
   logic [NB_DATA-1:0] rd_word, rd_shift, ld_data, wr_mask, wr_fill;

   assign idx         = i_addr[NB_IDX+1:2];
   assign lane        = i_addr[1:0];
   assign shamt       = {lane, 3'b000};
   assign unused_addr = ^{i_addr[NB_MEM_DATA_ADDR-1:NB_IDX+2]};
   assign is_byte     = i_load_store_selector == NB_LOAD_STORE_SEL'(1);
   assign is_half     = i_load_store_selector == NB_LOAD_STORE_SEL'(2);
   assign misaligned  = is_half ? lane[0] : !is_byte && lane != 2'b00;
   assign accept      = i_enable && !o_dump_busy && (i_wr_enable || i_rd_enable);
   assign rd_word     = mem[idx];
   assign rd_shift    = rd_word >> shamt;
   assign ld_data     = misaligned ? '0 :
                        is_byte ? {{(NB_DATA-8){!i_load_unsigned && rd_shift[7]}}, rd_shift[7:0]} :
                        is_half ? {{(NB_DATA-16){!i_load_unsigned && rd_shift[15]}}, rd_shift[15:0]} :
                        rd_word;
   assign wr_mask     = is_byte ? NB_DATA'(8'hFF) << shamt : is_half ? NB_DATA'(16'hFFFF) << shamt : '1;
   assign wr_fill     = is_byte ? {(NB_DATA/8){i_wr_data[7:0]}} :
                        is_half ? {(NB_DATA/16){i_wr_data[15:0]}} : i_wr_data;

   // Contents are intentionally not reset
   always_ff @(posedge i_clock)
      if (accept && i_wr_enable && !misaligned)
         mem[idx] <= (rd_word & ~wr_mask) | (wr_fill & wr_mask);

   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         o_data       <= '0;
         o_misaligned <= 1'b0;
      end else if (accept) begin
         o_misaligned <= misaligned;
         if (i_rd_enable)
            o_data <= ld_data;
      end

   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         o_dump_data <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && i_dump_start)
            ptr <= '0;
         else if (state == PRESENT && i_dump_ready && ptr != NB_IDX'(N_WORDS-1))
            ptr <= ptr + 1'b1;
         if (state == READ)
            o_dump_data <= mem[ptr];
      end

   always_comb begin
      next_state   = state;
      o_dump_valid = state == PRESENT;
      o_dump_busy  = state != IDLE;
      o_dump_done  = state == DONE;
      case (state)
         IDLE:    next_state = i_dump_start ? READ : IDLE;
         READ:    next_state = PRESENT;
         PRESENT: next_state = !i_dump_ready ? PRESENT : ptr == NB_IDX'(N_WORDS-1) ? DONE : READ;
         default: next_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: random and directed accesses against a byte-array model, plus dump and reset scenarios.
module tb_data_memory_responder;
   localparam int N_WORDS = 256;
   logic        clk = 0, rst_n = 0, en = 0, wr = 0, rd = 0, uns = 0, dstart = 0, dready = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic [1:0]  sel = 0;
   logic [31:0] data, ddata;
   logic        mis, dvalid, dbusy, ddone;
   logic [7:0]  mm [N_WORDS*4];
   logic [31:0] exp_data = 0;
   logic        exp_mis = 0;
   int          n_checks = 0, n_pass = 0;

   always #5 clk = ~clk;

   data_memory_responder dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_addr(addr), .i_wr_data(wdata),
      .i_wr_enable(wr), .i_rd_enable(rd), .i_load_store_selector(sel), .i_load_unsigned(uns),
      .o_data(data), .o_misaligned(mis), .i_dump_start(dstart), .o_dump_data(ddata),
      .o_dump_valid(dvalid), .i_dump_ready(dready), .o_dump_busy(dbusy), .o_dump_done(ddone)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] model_word(input int w);
      return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
   endfunction

   task automatic access(input logic e, input logic w, input logic r, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] d, input string tag);
      int          sz   = (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
      int          base = int'(a % (N_WORDS*4));
      bit          m    = (a % sz) != 0;
      logic [31:0] v    = 0;
      @(negedge clk);
      en = e; wr = w; rd = r; sel = s; uns = u; addr = a; wdata = d;
      if (e && (w || r)) begin
         exp_mis = m;
         if (r) begin
            if (!m) begin
               for (int k = 0; k < sz; k++) v |= 32'(mm[base+k]) << (8*k);
               if (!u && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8*sz)) - 1);
            end
            exp_data = v;
         end
         if (w && !m)
            for (int k = 0; k < sz; k++) mm[base+k] = d[8*k +: 8];
      end
      @(posedge clk);
      #1;
      if (r) check({tag, " data"}, data, exp_data);
      check({tag, " mis"}, 32'(mis), 32'(exp_mis));
      en = 0; wr = 0; rd = 0;
   endtask

   task automatic run_dump(input bit rnd, input bit poke, input string tag);
      int          got = 0, dones = 0, cyc = 0;
      logic [31:0] pdata = 0;
      bit          pvalid = 0, pready = 0;
      @(negedge clk);
      dstart = 1;
      @(negedge clk);
      dstart = 0;
      check({tag, " busy"}, 32'(dbusy), 32'd1);
      if (poke) begin
         en = 1; wr = 1; rd = 0; sel = 2'd0; addr = 32'h40; wdata = $urandom();
      end
      while (cyc < 20000 && !(dones > 0 && !dbusy)) begin
         if (dvalid && pvalid && !pready) check({tag, " stable"}, ddata, pdata);
         if (ddone) dones++;
         dready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (dvalid && dready) begin
            check({tag, " word"}, ddata, model_word(got % N_WORDS));
            got++;
         end
         pvalid = dvalid; pready = dready; pdata = ddata;
         @(negedge clk);
         cyc++;
      end
      dready = 0; en = 0; wr = 0;
      check({tag, " timeout"}, 32'(cyc < 20000), 32'd1);
      check({tag, " count"}, 32'(got), 32'(N_WORDS));
      check({tag, " done pulses"}, 32'(dones), 32'd1);
   endtask

   initial begin
      int cyc;
      #12;
      check("rst data", data, 32'd0);
      check("rst mis", 32'(mis), 32'd0);
      check("rst dump_data", ddata, 32'd0);
      check("rst valid", 32'(dvalid), 32'd0);
      check("rst busy", 32'(dbusy), 32'd0);
      check("rst done", 32'(ddone), 32'd0);
      @(negedge clk);
      rst_n = 1;
      for (int w = 0; w < N_WORDS; w++) access(1, 1, 0, 2'd0, 0, 32'(w*4), $urandom(), "init");
      access(1, 1, 0, 2'd0, 0, 32'h10, 32'hDEADBEEF, "st39");
      access(1, 0, 1, 2'd0, 0, 32'h10, 0, "ld39");
      check("req39 word", data, 32'hDEADBEEF);
      access(1, 1, 0, 2'd1, 0, 32'h13, 32'h000000A5, "stb40");
      access(1, 0, 1, 2'd1, 0, 32'h13, 0, "ldbs40");
      check("req40 signed", data, 32'hFFFFFFA5);
      access(1, 0, 1, 2'd1, 1, 32'h13, 0, "ldbu40");
      check("req40 unsigned", data, 32'h000000A5);
      access(1, 0, 1, 2'd3, 0, 32'h10, 0, "ldw40");
      check("req40 word", data, 32'hA5ADBEEF);
      access(1, 1, 0, 2'd2, 0, 32'h11, 32'h1234, "sth41");
      check("req41 store mis", 32'(mis), 32'd1);
      access(1, 0, 1, 2'd0, 0, 32'h10, 0, "ldw41");
      check("req41 unchanged", data, 32'hA5ADBEEF);
      access(1, 0, 1, 2'd2, 0, 32'h11, 0, "ldh41");
      check("req41 data", data, 32'd0);
      check("req41 mis", 32'(mis), 32'd1);
      access(1, 1, 0, 2'd0, 0, 32'h20, 32'h11111111, "st42a");
      access(1, 1, 1, 2'd0, 0, 32'h20, 32'h22222222, "rw42");
      check("req42 old", data, 32'h11111111);
      access(1, 0, 1, 2'd0, 0, 32'h20, 0, "ld42");
      check("req42 new", data, 32'h22222222);
      for (int i = 0; i < 400; i++)
         access(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 63)), $urandom(), "rand");
      run_dump(1, 1, "dump");
      access(1, 0, 1, 2'd0, 0, 32'h40, 0, "post-dump ld");
      @(negedge clk);
      dstart = 1;
      @(negedge clk);
      dstart = 0;
      dready = 0;
      cyc = 0;
      while (!dvalid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check("rst44 reached present", 32'(dvalid), 32'd1);
      #2 rst_n = 0;
      #1;
      check("rst44 valid", 32'(dvalid), 32'd0);
      check("rst44 busy", 32'(dbusy), 32'd0);
      check("rst44 dump_data", ddata, 32'd0);
      check("rst44 data", data, 32'd0);
      exp_data = 0; exp_mis = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("rst44 idle", 32'(dbusy), 32'd0);
      run_dump(1, 0, "restart");
      access(1, 0, 1, 2'd0, 0, 32'h10, 0, "final ld");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter NB_MEM_DATA_ADDR, default 32, meaning byte address width.
REQ-003 SHALL have parameter N_WORDS, default 256, a power of 2, meaning memory depth in words.
REQ-004 SHALL have parameter NB_LOAD_STORE_SEL, default 2, meaning access-size selector width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port i_clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_enable, input, 1, pipeline advance enable.
REQ-009 SHALL have port i_addr, input, NB_MEM_DATA_ADDR, byte address from the memory-access stage.
REQ-010 SHALL have port i_wr_data, input, NB_DATA, store data, right-aligned.
REQ-011 SHALL have port i_wr_enable, input, 1, store request.
REQ-012 SHALL have port i_rd_enable, input, 1, load request.
REQ-013 SHALL have port i_load_store_selector, input, NB_LOAD_STORE_SEL, access size: 00 word, 01 byte, 10 halfword, 11 word.
REQ-014 SHALL have port i_load_unsigned, input, 1, meaning 1 zero-extends loads and 0 sign-extends them.
REQ-015 SHALL have port o_data, output, NB_DATA, registered, extended load data.
REQ-016 SHALL have port o_misaligned, output, 1, registered flag for the last accepted access.
REQ-017 SHALL have port i_dump_start, input, 1, debug-unit request to stream the whole memory.
REQ-018 SHALL have port o_dump_data, output, NB_DATA, streamed word.
REQ-019 SHALL have port o_dump_valid, output, 1, o_dump_data valid.
REQ-020 SHALL have port i_dump_ready, input, 1, debug unit accepts the word.
REQ-021 SHALL have port o_dump_busy, output, 1, dump in progress.
REQ-022 SHALL have port o_dump_done, output, 1, one-cycle completion pulse.

Function
REQ-023 SHALL store N_WORDS x NB_DATA words; word index = i_addr[log2(N_WORDS)+1:2]; higher address bits are ignored, so accesses alias and wrap.
REQ-024 SHALL flag as misaligned a halfword access with i_addr[0]=1 and a word access with i_addr[1:0]!=0; byte accesses are never misaligned.
REQ-025 SHALL accept an access on a cycle where i_enable=1, o_dump_busy=0 and (i_wr_enable or i_rd_enable)=1; on accept, o_misaligned is registered; otherwise o_data and o_misaligned hold.
REQ-026 SHALL, on an accepted aligned store, write only the addressed lanes: word writes all 4 bytes; halfword writes bytes selected by i_addr[1] using i_wr_data[15:0]; byte writes the byte selected by i_addr[1:0] using i_wr_data[7:0].
REQ-027 SHALL suppress a misaligned store entirely, leaving memory unchanged.
REQ-028 SHALL, on an accepted aligned load, register the addressed lane into o_data one cycle later, sign- or zero-extended per i_load_unsigned; a word load ignores i_load_unsigned.
REQ-029 SHALL load 0 into o_data for a misaligned load.
REQ-030 SHALL, when load and store target the same word in one cycle, return the pre-write contents (read-first).
REQ-031 SHALL implement a dump FSM with states IDLE, READ, PRESENT and DONE.
REQ-032 SHALL, in IDLE with i_dump_start=1, clear the dump pointer and go to READ; i_dump_start is ignored in all other states.
REQ-033 SHALL, in READ, register mem[pointer] into o_dump_data and go to PRESENT.
REQ-034 SHALL, in PRESENT, assert o_dump_valid and hold o_dump_data stable until i_dump_ready=1; on ready it goes to DONE if pointer=N_WORDS-1, else increments the pointer and goes to READ.
REQ-035 SHALL, in DONE, assert o_dump_done for exactly one cycle and return to IDLE.
REQ-036 SHALL assert o_dump_busy in READ, PRESENT and DONE and block pipeline accesses (REQ-025) while busy.

Reset
REQ-037 SHALL, while i_reset_n=0 and immediately without waiting for a clock, force o_data=0, o_misaligned=0, o_dump_data=0, o_dump_valid=0, o_dump_busy=0, o_dump_done=0, dump pointer=0, FSM=IDLE.
REQ-038 SHALL NOT reset memory contents; contents after reset are undefined until written.

Verification
REQ-039 SHALL pass this test: word store 0xDEADBEEF at 0x10, then word load 0x10 -> o_data=0xDEADBEEF one cycle after accept, o_misaligned=0.
REQ-040 SHALL pass this test: after REQ-039, byte store 0x000000A5 at 0x13 -> signed byte load 0x13 gives 0xFFFFFFA5, unsigned gives 0x000000A5, word load 0x10 gives 0xA5ADBEEF.
REQ-041 SHALL pass this test: halfword store 0x1234 at 0x11 -> o_misaligned=1, word at 0x10 unchanged; halfword load at 0x11 -> o_data=0, o_misaligned=1.
REQ-042 SHALL pass this test: store and load to 0x20 in the same cycle (old 0x11111111, new 0x22222222) -> o_data=0x11111111, next load gives 0x22222222.
REQ-043 SHALL pass this test: dump with i_dump_ready randomly toggled -> N_WORDS words in index order, o_dump_data stable while valid and not ready, exactly one o_dump_done pulse, pipeline store during dump has no effect.
REQ-044 SHALL pass this test: i_reset_n low while in PRESENT -> o_dump_valid=0 and o_dump_busy=0 before the next clock edge, FSM=IDLE, and a new i_dump_start restarts from word 0.
